// File: rtl/manchester_tx_1553.sv
// MIL-STD-1553 Manchester II word encoder: command/data sync, 16 data bits MSB first,
// odd parity; back-to-back words while txen stays high, up to MAX_WORDS per message.
module manchester_tx_1553 #(
   parameter int unsigned HALF_CLKS = 25,
   parameter int unsigned MAX_WORDS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        txen,
   input  logic [15:0] dat,
   output logic        tx_p,
   output logic        tx_n,
   output logic        tx_inh,
   output logic        busy,
   output logic        word_done,
   output logic [3:0]  word_cnt
);

   localparam int unsigned CNT_W = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
   localparam int unsigned SLT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_PAR  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SLT_W-1:0]   slot_q, slot_d;
   logic [15:0]        shreg_q, shreg_d;
   logic               par_q, par_d;
   logic [3:0]         wcnt_q, wcnt_d;
   logic               txen_q;
   logic               tx_p_d, tx_n_d, tx_inh_d, busy_d, word_done_d;
   logic               start;
   logic               tick;
   logic               hi;
   logic               bit_v;
   logic [4:0]         wcnt_inc;

   assign start    = txen & ~txen_q;
   assign tick     = (cnt_q == CNT_W'(HALF_CLKS - 1));
   assign wcnt_inc = {1'b0, wcnt_q} + 5'd1;

   // Next state: half-slot timing and word sequencing
   always_comb begin
      state_d     = state_q;
      cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
      slot_d      = slot_q;
      shreg_d     = shreg_q;
      par_d       = par_q;
      wcnt_d      = wcnt_q;
      word_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = ST_SYNC;
               slot_d  = '0;
               wcnt_d  = 4'd0;
            end
         end
         ST_SYNC: begin
            if (tick) begin
               if (slot_q == SLT_W'(5)) begin
                  state_d = ST_DATA;
                  slot_d  = '0;
                  shreg_d = dat;
                  par_d   = ~^dat;
               end else begin
                  slot_d = slot_q + SLT_W'(1);
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (slot_q == SLT_W'(31)) begin
                  state_d = ST_PAR;
                  slot_d  = '0;
               end else begin
                  slot_d = slot_q + SLT_W'(1);
               end
            end
         end
         ST_PAR: begin
            word_done_d = (slot_q == SLT_W'(1)) && (cnt_q == CNT_W'(HALF_CLKS - 2));
            if (tick) begin
               if (slot_q == SLT_W'(1)) begin
                  wcnt_d = wcnt_inc[3:0];
                  slot_d = '0;
                  if (txen && (wcnt_inc < 5'(MAX_WORDS))) begin
                     state_d = ST_SYNC;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  slot_d = slot_q + SLT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line levels derived from the next state so tx outputs are registered
   always_comb begin
      hi       = 1'b0;
      bit_v    = shreg_d[4'd15 - slot_d[4:1]];
      tx_p_d   = 1'b0;
      tx_n_d   = 1'b0;
      tx_inh_d = 1'b1;
      busy_d   = 1'b0;
      case (state_d)
         ST_SYNC: hi = (wcnt_d == 4'd0) ? (slot_d < SLT_W'(3)) : (slot_d >= SLT_W'(3));
         ST_DATA: hi = slot_d[0] ? ~bit_v : bit_v;
         ST_PAR:  hi = slot_d[0] ? ~par_d : par_d;
         default: hi = 1'b0;
      endcase
      if (state_d != ST_IDLE) begin
         tx_p_d   = hi;
         tx_n_d   = ~hi;
         tx_inh_d = 1'b0;
         busy_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         slot_q    <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         wcnt_q    <= 4'd0;
         txen_q    <= 1'b0;
         tx_p      <= 1'b0;
         tx_n      <= 1'b0;
         tx_inh    <= 1'b1;
         busy      <= 1'b0;
         word_done <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         slot_q    <= slot_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         wcnt_q    <= wcnt_d;
         txen_q    <= txen;
         tx_p      <= tx_p_d;
         tx_n      <= tx_n_d;
         tx_inh    <= tx_inh_d;
         busy      <= busy_d;
         word_done <= word_done_d;
      end
   end

   assign word_cnt = wcnt_q;

endmodule

// File: tb/tb_manchester_tx_1553.sv
// Directed bench for manchester_tx_1553: line capture, Manchester decode and framing checks.
module tb_manchester_tx_1553;

   logic        clk = 1'b0;
   logic        rst;
   logic        txen;
   logic [15:0] dat;
   logic        tx_p, tx_n, tx_inh, busy, word_done;
   logic [3:0]  word_cnt;

   int total = 0;
   int bad   = 0;

   logic lines [$];
   int   busy_cnt = 0;
   int   wd_cnt   = 0;
   int   viol     = 0;

   manchester_tx_1553 #(.HALF_CLKS(25), .MAX_WORDS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .txen      (txen),
      .dat       (dat),
      .tx_p      (tx_p),
      .tx_n      (tx_n),
      .tx_inh    (tx_inh),
      .busy      (busy),
      .word_done (word_done),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   // Bus monitor: capture active line, count busy/word_done cycles, line legality
   always @(negedge clk) begin
      if (!tx_inh) lines.push_back(tx_p);
      if (busy) busy_cnt++;
      if (word_done) wd_cnt++;
      if ((tx_p & tx_n) || ((tx_p ^ tx_n) != !tx_inh)) viol++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic decode_word(input string tag, input int base, input int w,
                              input logic [15:0] exp_d, input logic exp_par);
      logic        lv [40];
      logic [5:0]  sync;
      logic [15:0] d;
      int          s, errs;
      s    = base + w * 1000;
      errs = 0;
      sync = '0;
      d    = '0;
      for (int k = 0; k < 40; k++) begin
         lv[k] = lines[s + k * 25];
         for (int j = 1; j < 25; j++)
            if (lines[s + k * 25 + j] !== lv[k]) errs++;
      end
      for (int k = 0; k < 6; k++) sync[5 - k] = lv[k];
      for (int i = 0; i < 16; i++) begin
         if (lv[6 + 2 * i] === lv[7 + 2 * i]) errs++;
         d[15 - i] = lv[6 + 2 * i];
      end
      if (lv[38] === lv[39]) errs++;
      chk($sformatf("%s_w%0d_sync", tag, w), 32'(sync), (w == 0) ? 32'h38 : 32'h07);
      chk($sformatf("%s_w%0d_data", tag, w), 32'(d), 32'(exp_d));
      chk($sformatf("%s_w%0d_par", tag, w), 32'(lv[38]), 32'(exp_par));
      chk($sformatf("%s_w%0d_code", tag, w), 32'(errs), 32'd0);
   endtask

   task automatic run_msg(input string tag, input int hi_len, input int glo, input int ghi,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic p0, input logic p1, input int exp_words);
      int base, bc0, wd0, v0, c;
      base = lines.size();
      bc0  = busy_cnt;
      wd0  = wd_cnt;
      v0   = viol;
      @(negedge clk);
      txen = 1'b1;
      dat  = d0;
      @(negedge clk);
      chk({tag, "_first"}, 32'({tx_p, tx_n, tx_inh, busy}), 32'b1001);
      c = 1;
      while ((c < hi_len || busy) && c < 12000) begin
         dat  = (c <= 1100) ? d0 : d1;
         txen = (c < hi_len) && !(c >= glo && c < ghi);
         if (c == 2100 && hi_len > 2100) chk({tag, "_noword3"}, 32'(busy), 32'd0);
         @(negedge clk);
         c++;
      end
      chk({tag, "_timeout"}, 32'(c >= 12000), 32'd0);
      txen = 1'b0;
      repeat (12) @(negedge clk);
      chk({tag, "_busylen"}, 32'(busy_cnt - bc0), 32'(exp_words * 1000));
      chk({tag, "_wdone"}, 32'(wd_cnt - wd0), 32'(exp_words));
      chk({tag, "_wcnt"}, 32'(word_cnt), 32'(exp_words));
      chk({tag, "_idle"}, 32'({tx_p, tx_n, tx_inh, busy}), 32'b0010);
      chk({tag, "_legal"}, 32'(viol - v0), 32'd0);
      chk({tag, "_linelen"}, 32'(lines.size() - base), 32'(exp_words * 1000));
      if (lines.size() >= base + 1000) decode_word(tag, base, 0, d0, p0);
      if (exp_words > 1 && lines.size() >= base + 2000) decode_word(tag, base, 1, d1, p1);
   endtask

   initial begin
      rst  = 1'b1;
      txen = 1'b0;
      dat  = '0;
      repeat (3) @(negedge clk);
      chk("reset", 32'({tx_p, tx_n, tx_inh, busy, word_done, word_cnt}), 32'b00100_0000);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // T1: two-word message, DEF0 (par 1) then 2233 (par 1)
      run_msg("t1", 2200, 0, 0, 16'hDEF0, 16'h2233, 1'b1, 1'b1, 2);
      // T2: single word 0001, parity 0
      run_msg("t2", 500, 0, 0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1);
      // T3: txen held long -> exactly two words, then a fresh message
      run_msg("t3a", 5000, 0, 0, 16'h0000, 16'h0000, 1'b1, 1'b1, 2);
      run_msg("t3b", 500, 0, 0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1);

      // T4: reset mid-word drops outputs asynchronously
      @(negedge clk);
      txen = 1'b1;
      dat  = 16'hA5A5;
      repeat (400) @(negedge clk);
      rst  = 1'b1;
      txen = 1'b0;
      #1;
      chk("t4_async", 32'({tx_p, tx_n, tx_inh, busy, word_cnt}), 32'b0010_0000);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      run_msg("t4", 500, 0, 0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1);

      // T6: txen glitch inside word 0 is ignored; one word only
      run_msg("t6", 500, 100, 110, 16'h8001, 16'h8001, 1'b1, 1'b1, 1);
      repeat (20) @(negedge clk);
      chk("t6_norestart", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
